seg_msg_player: RTL and testbench

SEG_MSG_PLAYER -- requirements
Module: seg_msg_player

---
 rtl/seg_msg_player_if.sv | 24 ++
 rtl/seg_msg_player.sv | 135 +++++++++++++
 tb/tb_seg_msg_player.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg_msg_player_if.sv
// Control inputs and display outputs of the seven-segment message player.
interface seg_msg_player_if #(
  parameter int RATE_W = 4,
  parameter int SEL_W  = 1
);
  logic [RATE_W-1:0] rate;
  logic [1:0]        mode;
  logic [SEL_W-1:0]  msg_sel;
  logic [3:0]        man_idx;
  logic              blink_en;
  logic [6:0]        segments;
  logic              decimal;
  logic              done;

  modport master (
    output rate, mode, msg_sel, man_idx, blink_en,
    input  segments, decimal, done
  );

  modport slave (
    input  rate, mode, msg_sel, man_idx, blink_en,
    output segments, decimal, done
  );
endinterface

// File: rtl/seg_msg_player.sv
// Plays stored 7-segment messages (manual, loop, ping-pong, one-shot) stepped by a prescaler tick.
// Outputs are registered: 1-cycle latency from pointer/inputs to segments; no backpressure.
module seg_msg_player #(
  parameter int DIV_W   = 16,
  parameter int MSG_LEN = 8,
  parameter int NUM_MSG = 2,
  parameter logic [NUM_MSG*MSG_LEN*7-1:0] MSG_TABLE = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b1111101, 7'b0111111, 7'b1110011, 7'b1010000,
    7'b0000000, 7'b0000000, 7'b0000000,
    7'b0111111, 7'b0111000, 7'b0111000, 7'b1111001, 7'b1110100
  }
) (
  input logic            clk,
  input logic            rst,
  seg_msg_player_if.slave bus
);

  localparam int SEL_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [3:0] LAST   = 4'(MSG_LEN - 1);
  localparam logic [3:0] PENULT = 4'(MSG_LEN - 2);

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             phase_q, phase_d;
  logic             done_q, done_d;
  logic [6:0]       seg_q, seg_d;
  logic             dec_q, dec_d;
  logic [1:0]       mode_q;
  logic [SEL_W-1:0] sel_q;

  mode_e      mode_now;
  logic       tick;
  logic       restart;
  logic [3:0] idx;
  logic [6:0] glyph;
  int         r;

  assign mode_now = mode_e'(bus.mode);

  always_comb begin
    r    = (int'(bus.rate) > DIV_W - 1) ? DIV_W - 1 : int'(bus.rate);
    tick = 1'b1;
    for (int i = 0; i < DIV_W; i++) begin
      if (i <= r) tick = tick & presc_q[i];
    end
  end

  // Restart on any mode/message change wins over a coincident tick.
  always_comb begin
    presc_d = presc_q + DIV_W'(1);
    phase_d = phase_q ^ tick;
    pos_d   = pos_q;
    dir_d   = dir_q;
    done_d  = done_q;
    restart = (bus.mode != mode_q) || (bus.msg_sel != sel_q);
    if (restart) begin
      pos_d  = 4'd0;
      dir_d  = 1'b0;
      done_d = 1'b0;
    end else begin
      if (tick) begin
        case (mode_now)
          MODE_LOOP:     pos_d = (pos_q >= LAST) ? 4'd0 : pos_q + 4'd1;
          MODE_PINGPONG: begin
            if (!dir_q) begin
              if (pos_q >= LAST) begin
                dir_d = 1'b1;
                pos_d = PENULT;
              end else begin
                pos_d = pos_q + 4'd1;
              end
            end else if (pos_q == 4'd0) begin
              dir_d = 1'b0;
              pos_d = 4'd1;
            end else begin
              pos_d = pos_q - 4'd1;
            end
          end
          MODE_ONESHOT:  if (pos_q < LAST) pos_d = pos_q + 4'd1;
          default:       pos_d = pos_q;
        endcase
      end
      if (mode_now == MODE_ONESHOT && pos_d == LAST) done_d = 1'b1;
    end
  end

  always_comb begin
    idx   = (mode_now == MODE_MANUAL) ? bus.man_idx : pos_q;
    glyph = 7'd0;
    for (int m = 0; m < NUM_MSG; m++) begin
      for (int c = 0; c < MSG_LEN; c++) begin
        if (int'(bus.msg_sel) == m && int'(idx) == c)
          glyph = MSG_TABLE[(m*MSG_LEN + c)*7 +: 7];
      end
    end
    seg_d = (!bus.blink_en || phase_q) ? glyph : 7'd0;
    dec_d = (mode_now != MODE_MANUAL) && phase_q;
  end

  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    sel_q  <= bus.msg_sel;
    if (rst) begin
      presc_q <= '0;
      pos_q   <= 4'd0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= 7'd0;
      dec_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.segments = seg_q;
  assign bus.decimal  = dec_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seg_msg_player.sv
// Bench for seg_msg_player: directed scenarios plus random mode/select/reset traffic vs a tick-count model.
module tb_seg_msg_player;
  localparam int L = 8;
  localparam logic [6:0] GH = 7'b1110100;
  localparam logic [6:0] GE = 7'b1111001;
  localparam logic [6:0] GL = 7'b0111000;
  localparam logic [6:0] GO = 7'b0111111;
  localparam logic [6:0] GR = 7'b1010000;
  localparam logic [6:0] GP = 7'b1110011;
  localparam logic [6:0] GG = 7'b1111101;
  localparam logic [6:0] BL = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_msg_player_if #(.RATE_W(4), .SEL_W(1)) bus ();
  seg_msg_player dut (.clk(clk), .rst(rst), .bus(bus));

  logic [6:0] tbl [2][L];
  int   vec   = 0;
  int   fails = 0;

  // Model state: cycles since reset, ticks since last restart, blink phase.
  int         cnt, nt;
  bit         ph;
  logic [1:0] prev_mode;
  logic       prev_sel;
  logic [6:0] e_seg;
  logic       e_dec, e_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [1:0] m, input int n);
    int k;
    case (m)
      2'd1: return n % L;
      2'd2: begin
        k = n % (2*L - 2);
        return (k < L) ? k : 2*L - 2 - k;
      end
      2'd3: return (n < L - 1) ? n : L - 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] glyph_of(input int s, input int i);
    if (s >= 2 || i >= L) return 7'd0;
    return tbl[s][i];
  endfunction

  task automatic step();
    int r, per, idx;
    bit tick, restart;
    @(posedge clk);
    if (rst) begin
      cnt = 0; nt = 0; ph = 1'b0;
      e_seg = 7'd0; e_dec = 1'b0;
      prev_mode = bus.mode;
      prev_sel  = bus.msg_sel;
    end else begin
      idx   = (bus.mode == 2'd0) ? int'(bus.man_idx) : pos_of(prev_mode, nt);
      e_seg = (!bus.blink_en || ph) ? glyph_of(int'(bus.msg_sel), idx) : 7'd0;
      e_dec = (bus.mode != 2'd0) ? ph : 1'b0;
      r    = (int'(bus.rate) > 15) ? 15 : int'(bus.rate);
      per  = 1 << (r + 1);
      tick = (cnt % per) == per - 1;
      if (tick) ph = ~ph;
      restart = (bus.mode != prev_mode) || (bus.msg_sel != prev_sel);
      if (restart) nt = 0;
      else if (tick) nt++;
      prev_mode = bus.mode;
      prev_sel  = bus.msg_sel;
      cnt = (cnt + 1) % 65536;
    end
    e_done = (prev_mode == 2'd3) && (nt >= L - 1);
    #1;
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("decimal",  32'(bus.decimal),  32'(e_dec));
    check("done",     32'(bus.done),     32'(e_done));
  endtask

  initial begin
    int guard;
    tbl[0] = '{GH, GE, GL, GL, GO, BL, BL, BL};
    tbl[1] = '{GR, GP, GO, GG, BL, BL, BL, BL};
    rst = 1'b1;
    bus.rate = 4'd0; bus.mode = 2'd1; bus.msg_sel = 1'b0;
    bus.man_idx = 4'd0; bus.blink_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();                        // LOOP, one step every 2 cycles
    bus.mode = 2'd2; repeat (40) step();       // PINGPONG sweeps
    bus.mode = 2'd3; bus.msg_sel = 1'b1;
    repeat (30) step();                        // ONESHOT to the end, done held
    bus.msg_sel = 1'b0; repeat (4) step();
    bus.mode = 2'd0; bus.man_idx = 4'd4; repeat (3) step();
    bus.man_idx = 4'd12; repeat (3) step();
    bus.mode = 2'd1; bus.blink_en = 1'b1; bus.rate = 4'd2;
    repeat (70) step();
    bus.blink_en = 1'b0; bus.rate = 4'd0; bus.mode = 2'd2;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(prev_mode == 2'd2 && (nt % (2*L - 2)) == 9) && guard < 100);
    check("pp_reach_pos5_down", 32'(guard < 100), 32'd1);
    rst = 1'b1; step();
    rst = 1'b0; repeat (30) step();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(39) == 0) bus.mode = 2'($urandom_range(3));
      if ($urandom_range(59) == 0) bus.msg_sel = ~bus.msg_sel;
      if ($urandom_range(7) == 0)  bus.man_idx = 4'($urandom_range(15));
      if ($urandom_range(49) == 0) bus.blink_en = ~bus.blink_en;
      if ($urandom_range(79) == 0) bus.rate = 4'($urandom_range(3));
      rst = ($urandom_range(199) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
